// File: rtl/dispense_sequencer.sv
// dispense_sequencer
//   Runs one pour of the alcohol dispenser. A start press is accepted only
//   when a cup is present; the cup must then stay present for DEBOUNCE_CYC
//   cycles before the pump is enabled for POUR_SECONDS seconds. Once per
//   second a one-cycle count_ack strobe decrements the display counter.
//   After the pour, the cup must be absent for DEBOUNCE_CYC cycles before
//   the next pour can be armed.
//
// Parameters
//   TICK_DIV      clk cycles per second (>= 2)
//   POUR_SECONDS  pour length in seconds (1..15)
//   DEBOUNCE_CYC  stable cup cycles required (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   RESET      in   asynchronous reset, active low
//   start      in   pour button (asynchronous level)
//   cup_sens   in   cup present sensor (asynchronous level, 1 = present)
//   pump_en    out  pump drive, high only while pouring
//   count_ack  out  one-cycle decrement strobe to the down counter
//   remaining  out  seconds left in the current pour
//   busy       out  high in any state except idle
//   done       out  one-cycle pulse on normal pour completion
//   fault      out  pour aborted flag
//
// Build option
//   DISPENSE_ABORT_EN  when defined, cup removal during a pour aborts it
//                      and sets fault; otherwise the pour always completes
//                      and fault is tied low.

module dispense_sequencer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int POUR_SECONDS = 5,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       start,
    input  logic       cup_sens,
    output logic       pump_en,
    output logic       count_ack,
    output logic [3:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       fault
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]    REM_LOAD   = 4'(POUR_SECONDS);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DEBOUNCE    = 3'd1,
        S_POUR        = 3'd2,
        S_DONE        = 3'd3,
        S_WAIT_REMOVE = 3'd4
    } state_t;

    // Input synchronizers and start edge detect
    logic start_s1, start_s2, start_prev;
    logic cup_s1, cup_s2;
    logic start_rise;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_prev <= 1'b0;
            cup_s1     <= 1'b0;
            cup_s2     <= 1'b0;
        end else begin
            start_s1   <= start;
            start_s2   <= start_s1;
            start_prev <= start_s2;
            cup_s1     <= cup_sens;
            cup_s2     <= cup_s1;
        end
    end

    assign start_rise = start_s2 & ~start_prev;

    // FSM and datapath state
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    rem_d;
    logic          ack_d;
`ifdef DISPENSE_ABORT_EN
    logic          fault_d;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        deb_d   = deb_q;
        rem_d   = remaining;
        ack_d   = 1'b0;
`ifdef DISPENSE_ABORT_EN
        fault_d = fault;
`endif
        unique case (state_q)
            S_IDLE: begin
                presc_d = '0;
                deb_d   = '0;
                if (start_rise && cup_s2) begin
                    state_d = S_DEBOUNCE;
`ifdef DISPENSE_ABORT_EN
                    fault_d = 1'b0;
`endif
                end
            end
            S_DEBOUNCE: begin
                if (!cup_s2) begin
                    state_d = S_IDLE;
                end else if (deb_q == DEB_LAST) begin
                    // this cycle is the DEBOUNCE_CYC-th stable one
                    state_d = S_POUR;
                    presc_d = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_POUR: begin
`ifdef DISPENSE_ABORT_EN
                if (!cup_s2) begin
                    state_d = S_IDLE;
                    fault_d = 1'b1;
                end else
`endif
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    ack_d   = 1'b1;
                    if (remaining != 4'd0)
                        rem_d = remaining - 4'd1;
                    if (remaining <= 4'd1)
                        state_d = S_DONE;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_DONE: begin
                deb_d   = '0;
                state_d = S_WAIT_REMOVE;
            end
            S_WAIT_REMOVE: begin
                if (cup_s2) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Reload keyed on the next state so remaining already reads full
        // on the first idle cycle, including after an abort.
        if (state_d == S_IDLE)
            rem_d = REM_LOAD;
    end

    // Outputs are registered from the next-state values so each one
    // changes on the same edge as the state transition that causes it.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            deb_q     <= '0;
            remaining <= REM_LOAD;
            count_ack <= 1'b0;
            pump_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            deb_q     <= deb_d;
            remaining <= rem_d;
            count_ack <= ack_d;
            pump_en   <= (state_d == S_POUR);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

`ifdef DISPENSE_ABORT_EN
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)
            fault <= 1'b0;
        else
            fault <= fault_d;
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_sequencer.sv
module tb_dispense_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int POUR_SECONDS = 5;
    localparam int DEBOUNCE_CYC = 3;

    localparam int M_IDLE = 0, M_DEB = 1, M_POUR = 2, M_DONE = 3, M_WAIT = 4;

    logic       clk = 1'b0;
    logic       RESET = 1'b0;
    logic       start = 1'b0;
    logic       cup_sens = 1'b0;
    logic       pump_en, count_ack, busy, done, fault;
    logic [3:0] remaining;

    dispense_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .POUR_SECONDS(POUR_SECONDS),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .start    (start),
        .cup_sens (cup_sens),
        .pump_en  (pump_en),
        .count_ack(count_ack),
        .remaining(remaining),
        .busy     (busy),
        .done     (done),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pour progress is tracked as elapsed pump cycles,
    // remaining time derives from that by division.
    int m_mode, m_deb, m_t, m_w;
    bit m_st1, m_st2, m_stp, m_cs1, m_cs2;
    bit m_fault, m_ack;

    // Per-pour observation of the DUT
    int  pump_cnt = 0, ack_cnt = 0;
    bit  prev_pump = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_deb = 0; m_t = 0; m_w = 0;
        m_st1 = 0; m_st2 = 0; m_stp = 0; m_cs1 = 0; m_cs2 = 0;
        m_fault = 0; m_ack = 0;
    endtask

    // One rising edge: decide on synchronized values seen before the edge,
    // then shift the pin values captured at this edge into the sync chain.
    task automatic model_step();
        bit rise;
        if (!RESET) begin
            model_reset();
            return;
        end
        rise  = m_st2 && !m_stp;
        m_ack = 0;
        case (m_mode)
            M_IDLE: if (rise && m_cs2) begin
                m_mode = M_DEB; m_deb = 0; m_fault = 0;
            end
            M_DEB: begin
                if (!m_cs2) m_mode = M_IDLE;
                else begin
                    m_deb++;
                    if (m_deb == DEBOUNCE_CYC) begin m_mode = M_POUR; m_t = 0; end
                end
            end
            M_POUR: begin
`ifdef DISPENSE_ABORT_EN
                if (!m_cs2) begin m_mode = M_IDLE; m_fault = 1; end else
`endif
                begin
                    m_t++;
                    if (m_t % TICK_DIV == 0) m_ack = 1;
                    if (m_t == POUR_SECONDS * TICK_DIV) m_mode = M_DONE;
                end
            end
            M_DONE: begin m_mode = M_WAIT; m_w = 0; end
            M_WAIT: begin
                if (m_cs2) m_w = 0; else m_w++;
                if (m_w == DEBOUNCE_CYC) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
        m_stp = m_st2; m_st2 = m_st1; m_st1 = start;
        m_cs2 = m_cs1; m_cs1 = cup_sens;
    endtask

    function automatic int exp_rem();
        if (m_mode == M_POUR) return POUR_SECONDS - m_t / TICK_DIV;
        if (m_mode == M_DONE || m_mode == M_WAIT) return 0;
        return POUR_SECONDS;
    endfunction

    task automatic check_outputs();
        chk("pump_en",   pump_en,   m_mode == M_POUR);
        chk("busy",      busy,      m_mode != M_IDLE);
        chk("done",      done,      m_mode == M_DONE);
        chk("count_ack", count_ack, m_ack);
        chk("remaining", remaining, exp_rem());
        chk("fault",     fault,     m_fault);
        if (pump_en && !prev_pump) begin pump_cnt = 0; ack_cnt = 0; end
        if (pump_en)   pump_cnt++;
        if (count_ack) ack_cnt++;
        if (done) begin
            chk("pour_len",  pump_cnt, POUR_SECONDS * TICK_DIV);
            chk("pour_acks", ack_cnt,  POUR_SECONDS);
        end
        prev_pump = pump_en;
    endtask

    task automatic cyc(input bit s, input bit c);
        start    = s;
        cup_sens = c;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    // Mid-cycle asynchronous reset, held across two edges.
    task automatic pulse_reset();
        #3;
        RESET = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_rst_pump", pump_en, 0);
        cyc(start, cup_sens);
        cyc(start, cup_sens);
        RESET = 1'b1;
    endtask

    // Press start with a cup present, keep the cup until the pour ends
    // (or until drop_at acks have been seen), then remove it and wait
    // for the sequencer to return to idle.
    task automatic run_pour(input int drop_at);
        int acks = 0;
        bit drop = 0;
        bit left_idle = 0;
        cyc(0, 1); cyc(0, 1); cyc(1, 1); cyc(1, 1);
        for (int i = 0; i < 300; i++) begin
            if (m_mode != M_IDLE) left_idle = 1;
            if (left_idle && m_mode == M_IDLE) return;
            cyc(0, !drop);
            if (m_ack) acks++;
            if (m_mode == M_DONE || (drop_at > 0 && acks >= drop_at)) drop = 1;
        end
        chk("pour_timeout", 0, 1);
    endtask

    initial begin
        bit s, c;
        int acks;
        model_reset();

        // Reset held with toggling inputs, then release
        for (int i = 0; i < 6; i++) cyc($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 0);
        chk("post_reset_rem", remaining, 5);

        // Normal pour
        run_pour(0);

        // Start without cup
        cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0);
        chk("nocup_busy", busy, 0);

        // Cup glitch during debounce, then a clean pour
        cyc(0, 1); cyc(0, 1); cyc(0, 1); cyc(1, 1); cyc(1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1);
        chk("glitch_busy", busy, 0);
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        run_pour(0);

        // Reset after the second second of a pour
        cyc(0, 1); cyc(0, 1); cyc(1, 1); cyc(1, 1);
        acks = 0;
        for (int i = 0; i < 100 && acks < 2; i++) begin
            cyc(0, 1);
            if (m_ack) acks++;
        end
        chk("midpour_acks", acks, 2);
        chk("midpour_pump", pump_en, 1);
        pulse_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0);
        chk("midpour_rem", remaining, 5);

        // Cup removed after second ack
        run_pour(2);
`ifdef DISPENSE_ABORT_EN
        chk("abort_fault", fault, 1);
`else
        chk("noabort_fault", fault, 0);
`endif
        run_pour(0);
        chk("fault_after_pour", fault, 0);

        // Random traffic
        s = 0; c = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) c = !c;
            if ($urandom_range(0, 7) == 0)  s = !s;
            if ($urandom_range(0, 599) == 0) pulse_reset();
            cyc(s, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Controller that runs one pour of the alcohol dispenser and drives the display down counter. It accepts a start request only when a cup is present and debounced, then runs the pump for a programmable number of seconds. Each elapsed second it issues a one-cycle decrement strobe to the downstream down counter and tracks the remaining time itself. It then waits for the cup to be removed before re-arming. It sits between the user inputs (button, cup sensor) and the pump driver / seven-segment countdown path.

## Interface
- TICK_DIV, 50_000_000: clk cycles per second tick; must be ≥2.
- POUR_SECONDS, 5: pour length in seconds; legal range 1..15.
- DEBOUNCE_CYC, 16: consecutive stable cycles required on the cup sensor; must be ≥1.
- clk  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  pour button, asynchronous level.
- cup_sens  in  1  cup-present sensor, asynchronous level, 1 = cup present.
- pump_en  out  1  pump drive; 1 only in POUR.
- count_ack  out  1  one-cycle decrement strobe to the down counter.
- remaining  out  4  seconds left in the current pour.
- busy  out  1  1 in any state except IDLE.
- done  out  1  one-cycle pulse when a pour completes normally.
- fault  out  1  pour-aborted flag; constant 0 unless DISPENSE_ABORT_EN is defined.

## Operation
- Input conditioning:
  - start and cup_sens each pass through a 2-flop synchronizer.
  - start_rise is the rising edge of the synchronized start: the registered previous value is compared with the current one.
- States: IDLE, DEBOUNCE, POUR, DONE, WAIT_REMOVE. Encoding is 3 bits and is implementation choice.
- IDLE:
  - remaining = POUR_SECONDS; prescaler cleared.
  - Goes to DEBOUNCE on start_rise with synchronized cup_sens = 1.
  - start_rise without a cup is ignored.
- DEBOUNCE:
  - The debounce counter increments while cup_sens = 1.
  - cup_sens = 0 returns to IDLE.
  - When the count reaches DEBOUNCE_CYC, goes to POUR with prescaler = 0.
- POUR:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - On the wrap cycle, count_ack = 1 and remaining decrements.
  - A wrap with remaining = 1 makes remaining 0 and goes to DONE.
  - start is ignored.
- DONE: done = 1 for exactly this one cycle. Unconditionally goes to WAIT_REMOVE.
- WAIT_REMOVE:
  - Requires DEBOUNCE_CYC consecutive cycles of cup_sens = 0, then goes to IDLE.
  - The debounce counter restarts whenever cup_sens = 1.
  - start is ignored.
- Arithmetic and widths:
  - Prescaler width is $clog2(TICK_DIV); debounce counter width is $clog2(DEBOUNCE_CYC+1).
  - remaining never underflows below 0; reload happens only in IDLE.
- count_ack fires exactly POUR_SECONDS times per completed pour and never outside POUR.

## Timing
- Reset values: pump_en = 0, count_ack = 0, done = 0, busy = 0, fault = 0, remaining = POUR_SECONDS. State = IDLE; all counters and synchronizers = 0.
- All outputs are registered and change only on a clk rising edge or on reset assertion.
- Pin-to-logic latency: a pin change is visible to the FSM 2 cycles later. start_rise appears 3 edges after start rises.
- pump_en rises on the edge that enters POUR and falls on the edge that leaves it.
- Pump on-time is exactly POUR_SECONDS × TICK_DIV cycles.
- count_ack is high on the same cycle that remaining shows the decremented value.
- Reset asserted mid-pour: pump_en drops immediately (asynchronous) and all outputs return to their reset values.

## Configuration
- DISPENSE_ABORT_EN defined:
  - In POUR, synchronized cup_sens = 0 for one cycle aborts the pour, with no debounce.
  - On the next edge: pump_en = 0, fault = 1, state = IDLE, remaining reloads, no count_ack and no done.
  - fault stays set until the next accepted start (IDLE to DEBOUNCE), then clears.
- DISPENSE_ABORT_EN undefined: cup removal during POUR is ignored, the pour completes, and fault is tied to 0.

## Test plan
All scenarios use TICK_DIV=4, POUR_SECONDS=5, DEBOUNCE_CYC=3.
- Reset check: hold RESET low, toggle inputs → pump_en = 0, busy = 0, remaining = 5. Release RESET → outputs unchanged.
- Normal pour: cup_sens = 1, start pulse → pump_en high for exactly 20 cycles.
  - 5 count_ack pulses 4 cycles apart; remaining steps 4,3,2,1,0.
  - done is a single pulse; busy stays 1 until the cup has been absent for 3 cycles, then remaining = 5.
- No cup: start pulse with cup_sens = 0 → stays IDLE, pump_en never asserts, no count_ack.
- Debounce glitch: cup_sens drops for 1 cycle during DEBOUNCE → return to IDLE, no pump. Re-press start with a stable cup → normal pour.
- Mid-pour reset: assert RESET after the 2nd count_ack → pump_en = 0 immediately. After release, remaining = 5 and state is IDLE.
- Cup removed mid-pour:
  - With DISPENSE_ABORT_EN: remove the cup after the 2nd count_ack → pump_en = 0 within 3 cycles, fault = 1, no done. fault clears on the next accepted start.
  - Without DISPENSE_ABORT_EN: same stimulus → full 5 count_ack pulses and done.
